// File: rtl/fx_mac_vec.sv
// Signed Q-format vector MAC: rounded/saturated products, symmetric-saturating accumulate, one result per in_last.
// Latency: pair sampled at edge k is accumulated at edge k+3; out_valid pulses in the following cycle.
// Backpressure: none; every in_valid beat is accepted, one term per clock.
module fx_mac_vec #(
    parameter int W     = 16,
    parameter int FRAC  = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_cnt
);

    typedef struct packed {
        logic vld;
        logic last;
    } tag_t;

    // Symmetric bounds: the most negative code is never produced.
    localparam logic signed [2*W-1:0] PMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] PMIN = -PMAX;
    localparam logic signed [2*W-1:0] RND  = {{(2*W-1){1'b0}}, 1'b1} << (FRAC-1);
    localparam logic signed [W:0]     AMAX = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0]     AMIN = -AMAX;

    tag_t                    s1_tag, s2_tag, s3_tag;
    logic [W-1:0]            s1_a, s1_b;
    logic [2*W-1:0]          a_ext, b_ext;
    logic signed [2*W-1:0]   s2_prod;
    logic signed [2*W-1:0]   rnd_sum, shifted;
    logic [W-1:0]            p_nx, s3_p;
    logic                    psat_nx, s3_psat;
    logic [W-1:0]            acc, acc_nx;
    logic signed [W:0]       acc_sum;
    logic                    asat_nx;
    logic                    sat_r, sat_nx;
    logic [CNT_W-1:0]        cnt_r, cnt_nx;

    // S1: operand capture; clr never kills this stage so a same-cycle pair starts the new vector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_tag <= '0;
            s1_a   <= '0;
            s1_b   <= '0;
        end else begin
            s1_tag <= '{vld: in_valid, last: in_last};
            if (in_valid) begin
                s1_a <= a;
                s1_b <= b;
            end
        end
    end

    assign a_ext = {{W{s1_a[W-1]}}, s1_a};
    assign b_ext = {{W{s1_b[W-1]}}, s1_b};

    // S2: full-width signed product (low 2W bits of the sign-extended multiply).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_tag  <= '0;
            s2_prod <= '0;
        end else begin
            s2_tag  <= clr ? tag_t'('0) : s1_tag;
            s2_prod <= a_ext * b_ext;
        end
    end

    assign rnd_sum = s2_prod + RND;
    assign shifted = rnd_sum >>> FRAC;

    always_comb begin
        p_nx    = shifted[W-1:0];
        psat_nx = 1'b0;
        if (shifted > PMAX) begin
            p_nx    = PMAX[W-1:0];
            psat_nx = 1'b1;
        end else if (shifted < PMIN) begin
            p_nx    = PMIN[W-1:0];
            psat_nx = 1'b1;
        end
    end

    // S3: rounded and clamped product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_tag  <= '0;
            s3_p    <= '0;
            s3_psat <= 1'b0;
        end else begin
            s3_tag  <= clr ? tag_t'('0) : s2_tag;
            s3_p    <= p_nx;
            s3_psat <= psat_nx;
        end
    end

    assign acc_sum = $signed({acc[W-1], acc}) + $signed({s3_p[W-1], s3_p});

    always_comb begin
        acc_nx  = acc_sum[W-1:0];
        asat_nx = 1'b0;
        if (acc_sum > AMAX) begin
            acc_nx  = AMAX[W-1:0];
            asat_nx = 1'b1;
        end else if (acc_sum < AMIN) begin
            acc_nx  = AMIN[W-1:0];
            asat_nx = 1'b1;
        end
    end

    assign sat_nx = sat_r | s3_psat | asat_nx;
    assign cnt_nx = (&cnt_r) ? cnt_r : cnt_r + 1'b1;

    // S4: accumulate; a last term publishes the updated state and restarts the vector in the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            sat_r     <= 1'b0;
            cnt_r     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_cnt   <= '0;
        end else begin
            out_valid <= 1'b0;
            if (clr) begin
                acc   <= '0;
                sat_r <= 1'b0;
                cnt_r <= '0;
            end else if (s3_tag.vld) begin
                if (s3_tag.last) begin
                    out_valid <= 1'b1;
                    out_data  <= acc_nx;
                    out_sat   <= sat_nx;
                    out_cnt   <= cnt_nx;
                    acc       <= '0;
                    sat_r     <= 1'b0;
                    cnt_r     <= '0;
                end else begin
                    acc   <= acc_nx;
                    sat_r <= sat_nx;
                    cnt_r <= cnt_nx;
                end
            end
        end
    end

endmodule
